// File: rtl/compare_pkg.sv
// Shared types and mode-field layout for the multi-channel comparator.
package compare_pkg;

    typedef enum logic [2:0] {
        RelEq     = 3'd0,
        RelNe     = 3'd1,
        RelGt     = 3'd2,
        RelGe     = 3'd3,
        RelLt     = 3'd4,
        RelLe     = 3'd5,
        RelNever  = 3'd6,
        RelAlways = 3'd7
    } rel_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StFired = 2'd2
    } chan_state_e;

    localparam int unsigned ModeW          = 4;
    localparam int unsigned ModeRelLsb     = 0;
    localparam int unsigned ModeRelW       = 3;
    localparam int unsigned ModeOneShotBit = 3;

endpackage

// File: rtl/compare_channel.sv
// One compare channel: relation decode, condition history, arm/fire FSM, event and sticky flag.
module compare_channel
    import compare_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ena,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [ModeW-1:0] mode,
    input  logic             sync,
    input  logic             arm,
    input  logic             disarm,
    input  logic             clr,
    output logic             match,
    output logic             evt,
    output logic             sticky,
    output logic             armed
);

    rel_e        rel;
    logic        one_shot;
    logic        cond_d, cond_q;
    logic        rise;
    logic        event_d, event_q;
    logic        sticky_d, sticky_q;
    chan_state_e state_d, state_q;

    assign rel      = rel_e'(mode[ModeRelLsb +: ModeRelW]);
    assign one_shot = mode[ModeOneShotBit];

    always_comb begin
        cond_d = 1'b0;
        case (rel)
            RelEq:     cond_d = (a == b);
            RelNe:     cond_d = (a != b);
            RelGt:     cond_d = (a >  b);
            RelGe:     cond_d = (a >= b);
            RelLt:     cond_d = (a <  b);
            RelLe:     cond_d = (a <= b);
            RelNever:  cond_d = 1'b0;
            RelAlways: cond_d = 1'b1;
            default:   cond_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rise    = ena && (state_q == StArmed) && cond_d && !cond_q;
        // A simultaneous arm+disarm is treated as a cancelled command: no event either.
        event_d = rise && !(arm && disarm);
        if (disarm) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (arm) state_d = StArmed;
                StArmed: if (rise && one_shot) state_d = StFired;
                StFired: if (arm) state_d = StArmed;
                default: state_d = StIdle;
            endcase
        end
        sticky_d = event_d || (sticky_q && !clr);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cond_q   <= 1'b0;
            state_q  <= StIdle;
            event_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (ena) begin
                cond_q <= cond_d;
            end
            state_q  <= state_d;
            event_q  <= event_d;
            sticky_q <= sticky_d;
        end
    end

    assign match  = cond_q && (cond_d || sync);
    assign evt    = event_q;
    assign sticky = sticky_q;
    assign armed  = (state_q == StArmed);

endmodule

// File: rtl/multi_channel_comparator.sv
// CHANNELS independent comparators against a shared reference; the event output is named evt
// because event is a reserved word.
module multi_channel_comparator
    import compare_pkg::*;
#(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      ena,
    input  logic [WIDTH-1:0]          a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    input  logic [CHANNELS*ModeW-1:0] mode,
    input  logic                      sync,
    input  logic [CHANNELS-1:0]       arm,
    input  logic [CHANNELS-1:0]       disarm,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       match,
    output logic [CHANNELS-1:0]       evt,
    output logic [CHANNELS-1:0]       sticky,
    output logic [CHANNELS-1:0]       armed
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        compare_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk    (clk),
            .srst   (srst),
            .ena    (ena),
            .a      (a),
            .b      (b[n*WIDTH +: WIDTH]),
            .mode   (mode[n*ModeW +: ModeW]),
            .sync   (sync),
            .arm    (arm[n]),
            .disarm (disarm[n]),
            .clr    (clr[n]),
            .match  (match[n]),
            .evt    (evt[n]),
            .sticky (sticky[n]),
            .armed  (armed[n])
        );
    end

endmodule

// File: tb/tb_multi_channel_comparator.sv
// Directed bench: stimulus queues expected per-cycle outputs, a monitor checks them after each edge.
module tb_multi_channel_comparator;

    localparam int W  = 8;
    localparam int CH = 4;

    localparam int SigMatch  = 0;
    localparam int SigEvt    = 1;
    localparam int SigSticky = 2;
    localparam int SigArmed  = 3;

    logic            clk = 1'b0;
    logic            srst;
    logic            ena;
    logic [W-1:0]    a;
    logic [CH*W-1:0] b;
    logic [CH*4-1:0] mode;
    logic            sync;
    logic [CH-1:0]   arm, disarm, clr;
    logic [CH-1:0]   match, evt, sticky, armed;

    multi_channel_comparator #(
        .WIDTH(W),
        .CHANNELS(CH)
    ) dut (
        .clk    (clk),
        .srst   (srst),
        .ena    (ena),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .sync   (sync),
        .arm    (arm),
        .disarm (disarm),
        .clr    (clr),
        .match  (match),
        .evt    (evt),
        .sticky (sticky),
        .armed  (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    sig;
        int    ch;
        bit    val;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    int s2_a [10] = '{49, 50, 51, 200, 255, 0, 1, 49, 50, 51};
    bit s2_ev[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit s2_ar[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Expectation applies to the outputs seen just after the next rising edge.
    task automatic expect_out(input string nm, input int sig, input int ch, input bit v);
        exp_t e;
        e.cyc  = cyc + 1;
        e.sig  = sig;
        e.ch   = ch;
        e.val  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic expect_all_zero(input string nm);
        for (int c = 0; c < CH; c++) begin
            for (int s = 0; s < 4; s++) begin
                expect_out(nm, s, c, 1'b0);
            end
        end
    endtask

    task automatic nx();
        @(negedge clk);
        arm    = '0;
        disarm = '0;
        clr    = '0;
    endtask

    task automatic set_mode(input int ch, input logic [3:0] m);
        mode[ch*4 +: 4] = m;
    endtask

    function automatic bit pick(input int sig, input int ch);
        case (sig)
            SigMatch:  return match[ch];
            SigEvt:    return evt[ch];
            SigSticky: return sticky[ch];
            default:   return armed[ch];
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        bit   act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e   = sbq.pop_front();
                act = pick(e.sig, e.ch);
                checks++;
                if (e.cyc == cyc && act === e.val) begin
                    passed++;
                end else begin
                    $display("FAIL %s sig%0d ch%0d cyc%0d: got %b expected %b", e.name, e.sig,
                             e.ch, cyc, act, e.val);
                end
            end
        end
    end

    initial begin : stim
        srst   = 1'b1;
        ena    = 1'b0;
        a      = '0;
        sync   = 1'b0;
        arm    = '0;
        disarm = '0;
        clr    = '0;
        b      = {8'd0, 8'd10, 8'd50, 8'd100};
        mode   = '0;
        set_mode(0, 4'b0011);
        set_mode(1, 4'b1000);
        set_mode(2, 4'b0010);
        set_mode(3, 4'b0110);

        @(negedge clk);
        expect_all_zero("reset");

        // GE 100 continuous, ramp through the threshold
        nx();
        srst   = 1'b0;
        ena    = 1'b1;
        a      = 8'd95;
        arm[0] = 1'b1;
        expect_out("ge_arm", SigArmed, 0, 1'b1);
        expect_out("ge_arm_evt", SigEvt, 0, 1'b0);
        for (int v = 96; v <= 105; v++) begin
            nx();
            a = 8'(v);
            expect_out("ge_evt", SigEvt, 0, v == 100);
            expect_out("ge_match", SigMatch, 0, v >= 100);
            expect_out("ge_sticky", SigSticky, 0, v >= 100);
        end

        // EQ 50 one-shot, two passes with wrap, then re-arm
        nx();
        a         = 8'd48;
        arm[1]    = 1'b1;
        disarm[0] = 1'b1;
        expect_out("eq_arm", SigArmed, 1, 1'b1);
        expect_out("ge_disarm", SigArmed, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            nx();
            a = 8'(s2_a[i]);
            expect_out("eq_evt", SigEvt, 1, s2_ev[i]);
            expect_out("eq_armed", SigArmed, 1, s2_ar[i]);
        end
        expect_out("eq_sticky", SigSticky, 1, 1'b1);
        nx();
        a      = 8'd52;
        arm[1] = 1'b1;
        expect_out("eq_rearm", SigArmed, 1, 1'b1);
        nx();
        a = 8'd255;
        expect_out("eq_p3_evt", SigEvt, 1, 1'b0);
        nx();
        a = 8'd0;
        expect_out("eq_p3_evt", SigEvt, 1, 1'b0);
        nx();
        a = 8'd50;
        expect_out("eq_p3_evt", SigEvt, 1, 1'b1);
        expect_out("eq_p3_fired", SigArmed, 1, 1'b0);

        // GT 10: arm with ena low while condition already true
        nx();
        a = 8'd5;
        expect_out("gt_low", SigMatch, 2, 1'b0);
        nx();
        a      = 8'd20;
        ena    = 1'b0;
        arm[2] = 1'b1;
        expect_out("gt_arm", SigArmed, 2, 1'b1);
        expect_out("gt_arm_evt", SigEvt, 2, 1'b0);
        expect_out("gt_arm_match", SigMatch, 2, 1'b0);
        nx();
        expect_out("gt_hold_evt", SigEvt, 2, 1'b0);
        expect_out("gt_hold_match", SigMatch, 2, 1'b0);
        nx();
        ena = 1'b1;
        expect_out("gt_ena_evt", SigEvt, 2, 1'b1);
        expect_out("gt_ena_match", SigMatch, 2, 1'b1);
        nx();
        expect_out("gt_after_evt", SigEvt, 2, 1'b0);

        // arm+disarm together, then event coinciding with clr
        nx();
        arm[3]    = 1'b1;
        disarm[3] = 1'b1;
        a         = 8'd5;
        expect_out("armdis_armed", SigArmed, 3, 1'b0);
        expect_out("armdis_evt", SigEvt, 3, 1'b0);
        expect_out("clr_pre_evt", SigEvt, 2, 1'b0);
        nx();
        a      = 8'd20;
        clr[2] = 1'b1;
        expect_out("clr_evt", SigEvt, 2, 1'b1);
        expect_out("clr_set_wins", SigSticky, 2, 1'b1);
        nx();
        clr[2] = 1'b1;
        expect_out("clr_alone_evt", SigEvt, 2, 1'b0);
        expect_out("clr_alone", SigSticky, 2, 1'b0);

        // sync qualifier on a falling condition
        nx();
        a   = 8'd5;
        ena = 1'b0;
        expect_out("sync0_match", SigMatch, 2, 1'b0);
        nx();
        sync = 1'b1;
        expect_out("sync1_match", SigMatch, 2, 1'b1);
        nx();
        ena = 1'b1;
        expect_out("sync1_edge_match", SigMatch, 2, 1'b0);
        expect_out("sync1_edge_evt", SigEvt, 2, 1'b0);

        // reset mid-operation with a rise pending on ch0
        nx();
        sync   = 1'b0;
        arm[0] = 1'b1;
        expect_out("pre_rst_armed", SigArmed, 0, 1'b1);
        nx();
        a    = 8'd150;
        srst = 1'b1;
        arm  = '1;
        expect_all_zero("mid_reset");

        // NEVER then ALWAYS on ch3
        nx();
        srst   = 1'b0;
        arm[3] = 1'b1;
        expect_out("never_arm", SigArmed, 3, 1'b1);
        expect_out("never_evt", SigEvt, 3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            nx();
            expect_out("never_evt", SigEvt, 3, 1'b0);
        end
        nx();
        set_mode(3, 4'b0111);
        expect_out("always_evt", SigEvt, 3, 1'b1);
        expect_out("always_match", SigMatch, 3, 1'b1);
        nx();
        expect_out("always_once", SigEvt, 3, 1'b0);
        expect_out("always_sticky", SigSticky, 3, 1'b1);
        nx();
        expect_out("always_once", SigEvt, 3, 1'b0);

        nx();
        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sbq.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
            checks += sbq.size();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_comparator.md
MULTI_CHANNEL_COMPARATOR -- requirements
Module: multi_channel_comparator

Interface
REQ-001 Parameter WIDTH, default 24: bit width of the compared values, unsigned.
REQ-002 Parameter CHANNELS, default 4: number of independent compare channels.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port srst  input  1  reset, synchronous, active-high.
REQ-005 Port ena  input  1  clock enable for comparison history and event generation.
REQ-006 Port a  input  WIDTH  shared reference value, e.g. the tooth/angle counter.
REQ-007 Port b  input  CHANNELS*WIDTH  per-channel threshold; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-008 Port mode  input  CHANNELS*4  per-channel control; bits [2:0] select the relation, bit [3] selects one-shot.
REQ-009 Port sync  input  1  match-qualifier override, same meaning for all channels.
REQ-010 Port arm, disarm, clr  input  CHANNELS each  per-channel single-cycle commands.
REQ-011 Port match  output  CHANNELS  qualified level result.
REQ-012 Port event  output  CHANNELS  one-cycle pulse on a qualified rising condition.
REQ-013 Port sticky  output  CHANNELS  latched event flag.
REQ-014 Port armed  output  CHANNELS  1 when the channel is in state ARMED.

Function
REQ-015 Relation encoding, unsigned compare of a against b[n]: 0 EQ, 1 NE, 2 GT, 3 GE, 4 LT, 5 LE, 6 NEVER (constant 0), 7 ALWAYS (constant 1); the result is cond_d[n], which is combinational.
REQ-016 On an edge with ena=1, cond_q[n] <= cond_d[n]; with ena=0, cond_q holds.
REQ-017 match[n] = cond_q[n] & (cond_d[n] | sync), combinational from the register and current inputs; no extra latency.
REQ-018 Per-channel FSM has three states: IDLE, ARMED, FIRED.
REQ-019 FSM transitions: IDLE --arm--> ARMED; ARMED --qualified rise & one-shot--> FIRED; FIRED --arm--> ARMED; any state --disarm--> IDLE; otherwise the state holds.
REQ-020 Qualified rise at an edge: ena=1, state ARMED before the edge, cond_d=1, cond_q=0.
REQ-021 A qualified rise sets the registered event[n]=1 for exactly the following cycle; event is 0 at every other edge.
REQ-022 In continuous mode (mode[3]=0), the channel stays ARMED after an event and re-fires on every subsequent qualified rise.
REQ-023 arm and disarm asserted together: disarm wins, next state IDLE, and no event is generated at that edge.
REQ-024 disarm asserted together with a qualified rise: the event fires and the next state is IDLE.
REQ-025 arm applied at the same edge as a qualified-rise condition: no event, because the state before the edge was not ARMED.
REQ-026 sticky[n] is set by an event at the same edge event registers, and cleared by clr[n]; a set coinciding with clr wins, so sticky=1.
REQ-027 arm, disarm and clr act regardless of ena.
REQ-028 A mode or b change that flips cond_d from 0 to 1 while ARMED and ena=1 counts as a qualified rise.
REQ-029 Value wrap-around of a is handled by plain unsigned compare; there is no modular comparison.
REQ-030 Channels are fully independent; any combination of simultaneous events is permitted.

Reset
REQ-031 While srst=1 at an edge: cond_q=0, state=IDLE, event=0, sticky=0; all commands and ena are ignored.
REQ-032 After reset the outputs are: match=0, event=0, sticky=0, armed=0.
REQ-033 Because cond_q resets to 0, a condition already true when a channel is first armed produces an event on the first enabled edge in ARMED.

Structure
REQ-034 A shared package compare_pkg holds the relation enum (3 bits), the channel state enum, and the mode field bit positions.
REQ-035 A single sub-module compare_channel implements one channel (comparator, cond_q, FSM, event, sticky); the top instantiates CHANNELS copies by generate and only slices the buses.

Verification
REQ-036 WIDTH=8, ch0 GE b=100, continuous, armed; ramp a 95..105 with ena=1 -> event0 high exactly one cycle, the cycle after the edge sampling a=100; sticky0=1; match0 high from then on.
REQ-037 ch1 EQ b=50, one-shot, armed; a ramps through 50 twice (wrapping 255->0) -> one event only; state FIRED; re-arm, then third pass -> second event.
REQ-038 ch2 GT b=10 with a=20 already present, arm -> event on the first enabled edge after arm, not at the arm edge; hold ena=0 during a rise -> no event, cond_q unchanged.
REQ-039 Simultaneous arm+disarm -> armed=0 and no event; event with clr at the same edge -> sticky stays 1; clr alone next cycle -> sticky 0.
REQ-040 sync=0 with cond_d dropping while cond_q=1 -> match=0 that cycle; sync=1 -> match=1 until the next enabled edge.
REQ-041 srst asserted mid-operation (ARMED, sticky=1, event pending) -> next cycle all outputs 0, state IDLE; NEVER/ALWAYS modes -> no event, and one event after arm, respectively.
